// File: rtl/game_engine_pkg.sv
// Shared definitions for the game core and the display block: state codes, default widths, gamedata bus layout.
package game_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam int DEF_SLOTS  = 4;
    localparam int DEF_XW     = 8;
    localparam int DEF_YW     = 6;
    localparam int DEF_SCOREW = 16;

    // gamedata bus layout, LSB first: player_y | obst_x | obst_valid | score
    localparam int GD_PLAYER_Y_OFF   = 0;
    localparam int GD_OBST_X_OFF     = GD_PLAYER_Y_OFF + DEF_YW;
    localparam int GD_OBST_VALID_OFF = GD_OBST_X_OFF + DEF_SLOTS * DEF_XW;
    localparam int GD_SCORE_OFF      = GD_OBST_VALID_OFF + DEF_SLOTS;
    localparam int GD_W              = GD_SCORE_OFF + DEF_SCOREW;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/game_engine_obstacle_slot.sv
// One obstacle slot: holds x/valid, moves left on each run step, expires below SPEED, loads at the right edge.
// x_nxt/valid_nxt expose the post-step values so the parent can test collision on the same tick.
module game_engine_obstacle_slot #(
    parameter int XW       = 8,
    parameter int SCREEN_X = 160,
    parameter int SPEED    = 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    input  logic          load,
    output logic [XW-1:0] x,
    output logic          valid,
    output logic [XW-1:0] x_nxt,
    output logic          valid_nxt
);

    always_comb begin
        x_nxt     = x;
        valid_nxt = valid;
        if (clear) begin
            x_nxt     = '0;
            valid_nxt = 1'b0;
        end else if (step) begin
            if (valid) begin
                if (x < XW'(SPEED))
                    valid_nxt = 1'b0;
                else
                    x_nxt = x - XW'(SPEED);
            end else if (load) begin
                x_nxt     = XW'(SCREEN_X - 1);
                valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            x     <= '0;
            valid <= 1'b0;
        end else begin
            x     <= x_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: rtl/game_engine.sv
// Little Dinosaur game core: FSM, jump physics, LFSR-spawned obstacle slots, collision and scoring.
// Game state advances only on tick; all outputs are registered (visible the cycle after the tick).
module game_engine
    import game_engine_pkg::*;
#(
    parameter int          SLOTS         = DEF_SLOTS,
    parameter int          XW            = DEF_XW,
    parameter int          YW            = DEF_YW,
    parameter int          SCREEN_X      = 160,
    parameter int          SPEED         = 1,
    parameter int          PLAYER_X      = 16,
    parameter int          PLAYER_W      = 8,
    parameter int          OBST_W        = 6,
    parameter int          OBST_H        = 8,
    parameter int          JUMP_V        = 4,
    parameter int          GRAVITY       = 1,
    parameter int          SPAWN_MIN_GAP = 24,
    parameter int          SPAWN_THRESH  = 4,
    parameter int          SCOREW        = DEF_SCOREW,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  jump,
    output logic [1:0]            state,
    output logic [YW-1:0]         player_y,
    output logic [SLOTS*XW-1:0]   obst_x,
    output logic [SLOTS-1:0]      obst_valid,
    output logic [SCOREW-1:0]     score,
    output logic [SCOREW-1:0]     hi_score,
    output logic                  collide
);

    localparam int VW = YW + 1;
    localparam int SW = YW + 2;
    localparam int GW = $clog2(SPAWN_MIN_GAP + 2);

    localparam logic signed [VW-1:0] JV      = VW'(JUMP_V);
    localparam logic signed [VW-1:0] GV      = VW'(GRAVITY);
    localparam logic [GW-1:0]        GAP_MAX = GW'(SPAWN_MIN_GAP);
    localparam logic [4:0]           THR     = 5'(SPAWN_THRESH);
    localparam logic [XW:0]          P_RIGHT = (XW+1)'(PLAYER_X + PLAYER_W);
    localparam logic [XW:0]          P_LEFT  = (XW+1)'(PLAYER_X);
    localparam logic [XW:0]          O_W     = (XW+1)'(OBST_W);
    localparam logic [YW:0]          O_H     = (YW+1)'(OBST_H);

    state_t                 st, st_nxt;
    logic signed [VW-1:0]   vel, vel_nxt;
    logic [YW-1:0]          y_nxt;
    logic signed [SW-1:0]   y_sum;
    logic [15:0]            lfsr;
    logic                   jump_prev, jump_req, jreq;
    logic [GW-1:0]          gap, gap_nxt;
    logic [SCOREW-1:0]      score_nxt, hi_nxt;
    logic                   collide_nxt;
    logic                   run_step, clear, spawn;
    logic [SLOTS-1:0]       load, valid_nxt, hits;
    logic [SLOTS*XW-1:0]    x_nxt_all;

    // An edge arriving on the tick cycle itself still counts for that tick
    assign jreq     = jump_req | (jump & ~jump_prev);
    assign run_step = tick && (st == ST_RUN);
    assign clear    = tick && jreq && ((st == ST_IDLE) || (st == ST_DEAD));

    // Spawn looks at pre-tick occupancy, so a slot expiring this tick is not reused until the next one
    assign spawn = run_step && (gap >= GAP_MAX) && ({1'b0, lfsr[3:0]} < THR) && !(&obst_valid);
    assign load  = spawn ? (~obst_valid & (obst_valid + SLOTS'(1))) : '0;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [XW:0] xe;

        game_engine_obstacle_slot #(
            .XW       (XW),
            .SCREEN_X (SCREEN_X),
            .SPEED    (SPEED)
        ) u_slot (
            .clock     (clock),
            .rst       (rst),
            .step      (run_step),
            .clear     (clear),
            .load      (load[i]),
            .x         (obst_x[i*XW +: XW]),
            .valid     (obst_valid[i]),
            .x_nxt     (x_nxt_all[i*XW +: XW]),
            .valid_nxt (valid_nxt[i])
        );

        assign xe      = {1'b0, x_nxt_all[i*XW +: XW]};
        assign hits[i] = valid_nxt[i] && (xe < P_RIGHT) && ((xe + O_W) > P_LEFT)
                         && ({1'b0, y_nxt} < O_H);
    end

    always_comb begin
        y_nxt   = player_y;
        vel_nxt = vel;
        y_sum   = $signed({2'b00, player_y}) + SW'(vel);
        if (clear) begin
            y_nxt   = '0;
            vel_nxt = '0;
        end else if (run_step) begin
            if (player_y == '0 && vel == '0) begin
                if (jreq)
                    vel_nxt = JV;
            end else if (y_sum <= 0) begin
                y_nxt   = '0;
                vel_nxt = '0;
            end else begin
                y_nxt   = y_sum[YW-1:0];
                vel_nxt = vel - GV;
            end
        end
    end

    always_comb begin
        st_nxt      = st;
        score_nxt   = score;
        hi_nxt      = hi_score;
        gap_nxt     = gap;
        collide_nxt = 1'b0;
        if (tick) begin
            case (st)
                ST_IDLE: begin
                    if (jreq) begin
                        st_nxt    = ST_RUN;
                        score_nxt = '0;
                        gap_nxt   = GAP_MAX;
                    end
                end
                ST_RUN: begin
                    if (spawn)
                        gap_nxt = '0;
                    else if (gap < GAP_MAX)
                        gap_nxt = gap + GW'(1);
                    if (|hits) begin
                        st_nxt      = ST_DEAD;
                        collide_nxt = 1'b1;
                        hi_nxt      = (score > hi_score) ? score : hi_score;
                    end else if (score != '1) begin
                        score_nxt = score + SCOREW'(1);
                    end
                end
                ST_DEAD: begin
                    if (jreq)
                        st_nxt = ST_IDLE;
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            player_y  <= '0;
            vel       <= '0;
            score     <= '0;
            hi_score  <= '0;
            collide   <= 1'b0;
            gap       <= GAP_MAX;
            lfsr      <= LFSR_SEED;
            jump_prev <= 1'b0;
            jump_req  <= 1'b0;
        end else begin
            st        <= st_nxt;
            player_y  <= y_nxt;
            vel       <= vel_nxt;
            score     <= score_nxt;
            hi_score  <= hi_nxt;
            collide   <= collide_nxt;
            gap       <= gap_nxt;
            lfsr      <= lfsr_next(lfsr);
            jump_prev <= jump;
            jump_req  <= tick ? 1'b0 : jreq;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_game_engine.sv
// Directed bench: DUT a (4 slots, always-spawn) covers jump arc, collision, restart, reset;
// DUT b (2 slots, no gap, player off-screen) covers slot exhaustion and same-tick expiry/spawn.
module tb_game_engine;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    logic tick_a = 1'b0, jump_a = 1'b0, tick_b = 1'b0, jump_b = 1'b0;

    logic [1:0]  state_a, state_b;
    logic [5:0]  y_a, y_b;
    logic [31:0] ox_a;
    logic [15:0] ox_b;
    logic [3:0]  ov_a;
    logic [1:0]  ov_b;
    logic [15:0] score_a, score_b, hi_a, hi_b;
    logic        col_a, col_b;

    int passes = 0;
    int total  = 0;

    always #5 clock = ~clock;

    game_engine #(.SPAWN_THRESH(16)) dut_a (
        .clock(clock), .rst(rst), .tick(tick_a), .jump(jump_a),
        .state(state_a), .player_y(y_a), .obst_x(ox_a), .obst_valid(ov_a),
        .score(score_a), .hi_score(hi_a), .collide(col_a)
    );

    game_engine #(.SLOTS(2), .SPAWN_MIN_GAP(0), .SPAWN_THRESH(16), .PLAYER_X(200)) dut_b (
        .clock(clock), .rst(rst), .tick(tick_b), .jump(jump_b),
        .state(state_b), .player_y(y_b), .obst_x(ox_b), .obst_valid(ov_b),
        .score(score_b), .hi_score(hi_b), .collide(col_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // one clock; b selects which DUT receives tick/jump
    task automatic cyc(input bit t, input bit j, input bit b);
        tick_a = t & ~b;
        jump_a = j & ~b;
        tick_b = t & b;
        jump_b = j & b;
        @(posedge clock);
        #1;
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    task automatic press(input bit b);
        cyc(1'b0, 1'b1, b);
        cyc(1'b0, 1'b0, b);
    endtask

    task automatic ticks(input int n, input bit b);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, b);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_state", 32'(state_a), 0);
        chk("rst_y", 32'(y_a), 0);
        chk("rst_valid", 32'(ov_a), 0);
        chk("rst_score", 32'(score_a), 0);
        chk("rst_hi", 32'(hi_a), 0);
        chk("rst_collide", 32'(col_a), 0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        // IDLE ignores ticks without a jump
        ticks(1, 0);
        chk("idle_hold", 32'(state_a), 0);

        press(0); ticks(1, 0);
        chk("start_state", 32'(state_a), 1);
        chk("start_score", 32'(score_a), 0);
        chk("start_valid", 32'(ov_a), 0);

        // run tick 1: jump sets velocity only; slot0 spawns
        press(0); ticks(1, 0);
        chk("t1_y", 32'(y_a), 0);
        chk("t1_valid", 32'(ov_a), 1);
        chk("t1_x0", 32'(ox_a[7:0]), 159);
        chk("t1_score", 32'(score_a), 1);
        ticks(1, 0); chk("arc_y2", 32'(y_a), 4);
        ticks(1, 0); chk("arc_y3", 32'(y_a), 7);
        ticks(1, 0); chk("arc_y4", 32'(y_a), 9);
        press(0);                    // airborne jump must be ignored
        ticks(1, 0); chk("arc_y5", 32'(y_a), 10);
        ticks(1, 0); chk("arc_y6", 32'(y_a), 10);
        ticks(1, 0); chk("arc_y7", 32'(y_a), 9);
        ticks(1, 0); chk("arc_y8", 32'(y_a), 7);
        ticks(1, 0); chk("arc_y9", 32'(y_a), 4);
        ticks(1, 0); chk("arc_y10", 32'(y_a), 0);
        ticks(1, 0); chk("arc_y11", 32'(y_a), 0);
        chk("t11_score", 32'(score_a), 11);
        chk("t11_x0", 32'(ox_a[7:0]), 149);

        // jump at t134 clears slot0 at x=23..20, lands on it at x=19
        ticks(122, 0);
        press(0); ticks(1, 0);
        chk("t134_y", 32'(y_a), 0);
        ticks(6, 0);
        chk("t140_state", 32'(state_a), 1);
        chk("t140_y", 32'(y_a), 9);
        chk("t140_score", 32'(score_a), 140);
        chk("t140_x0", 32'(ox_a[7:0]), 20);
        chk("t140_collide", 32'(col_a), 0);
        ticks(1, 0);
        chk("hit1_state", 32'(state_a), 2);
        chk("hit1_collide", 32'(col_a), 1);
        chk("hit1_score", 32'(score_a), 140);
        chk("hit1_hi", 32'(hi_a), 140);
        chk("hit1_y", 32'(y_a), 7);
        chk("hit1_x0", 32'(ox_a[7:0]), 19);
        chk("hit1_valid", 32'(ov_a), 15);
        cyc(1'b0, 1'b0, 0);
        chk("pulse_end", 32'(col_a), 0);
        chk("dead_state", 32'(state_a), 2);
        ticks(1, 0);
        chk("dead_frozen_x0", 32'(ox_a[7:0]), 19);
        chk("dead_frozen_state", 32'(state_a), 2);

        press(0); ticks(1, 0);
        chk("restart_state", 32'(state_a), 0);
        chk("restart_valid", 32'(ov_a), 0);
        chk("restart_score", 32'(score_a), 140);
        chk("restart_hi", 32'(hi_a), 140);
        chk("restart_y", 32'(y_a), 0);

        // second run: no jumping, dies at x=23 with 136 < 140
        press(0); ticks(1, 0);
        chk("run2_state", 32'(state_a), 1);
        chk("run2_score", 32'(score_a), 0);
        ticks(136, 0);
        chk("run2_t136_state", 32'(state_a), 1);
        chk("run2_t136_score", 32'(score_a), 136);
        chk("run2_t136_hi", 32'(hi_a), 140);
        ticks(1, 0);
        chk("hit2_state", 32'(state_a), 2);
        chk("hit2_collide", 32'(col_a), 1);
        chk("hit2_score", 32'(score_a), 136);
        chk("hit2_hi", 32'(hi_a), 140);
        chk("hit2_x0", 32'(ox_a[7:0]), 23);

        // DUT b: exhaustion and same-tick expiry/spawn
        press(1); ticks(1, 1);
        chk("b_start", 32'(state_b), 1);
        ticks(1, 1);
        chk("b_t1_valid", 32'(ov_b), 1);
        chk("b_t1_x0", 32'(ox_b[7:0]), 159);
        ticks(1, 1);
        chk("b_t2_valid", 32'(ov_b), 3);
        chk("b_t2_x0", 32'(ox_b[7:0]), 158);
        chk("b_t2_x1", 32'(ox_b[15:8]), 159);
        ticks(1, 1);
        chk("b_t3_valid", 32'(ov_b), 3);
        chk("b_t3_x0", 32'(ox_b[7:0]), 157);
        chk("b_t3_x1", 32'(ox_b[15:8]), 158);
        ticks(157, 1);
        chk("b_t160_x0", 32'(ox_b[7:0]), 0);
        chk("b_t160_x1", 32'(ox_b[15:8]), 1);
        chk("b_t160_valid", 32'(ov_b), 3);
        ticks(1, 1);
        chk("b_t161_valid", 32'(ov_b), 2);
        chk("b_t161_x1", 32'(ox_b[15:8]), 0);
        ticks(1, 1);
        chk("b_t162_valid", 32'(ov_b), 1);
        chk("b_t162_x0", 32'(ox_b[7:0]), 159);
        chk("b_t162_score", 32'(score_b), 162);
        chk("b_t162_state", 32'(state_b), 1);

        // asynchronous reset mid-RUN with the player airborne
        press(0); ticks(1, 0);
        press(0); ticks(1, 0);
        press(0); ticks(2, 0);
        chk("pre_rst_y", 32'(y_a), 4);
        chk("pre_rst_state", 32'(state_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state_a), 0);
        chk("arst_y", 32'(y_a), 0);
        chk("arst_valid", 32'(ov_a), 0);
        chk("arst_x", ox_a, 0);
        chk("arst_score", 32'(score_a), 0);
        chk("arst_hi", 32'(hi_a), 0);
        chk("arst_collide", 32'(col_a), 0);
        chk("arst_b_state", 32'(state_b), 0);
        chk("arst_b_y", 32'(y_b), 0);
        chk("arst_b_hi", 32'(hi_b), 0);
        chk("arst_b_collide", 32'(col_b), 0);
        #3 rst = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/game_engine.md
Name: game_engine

Overview:
- Parametrised game-logic core for the Little Dinosaur design; it replaces the fixed single-enemy, single-player update logic.
- Runs the game state machine, player jump physics, SLOTS independent obstacles with LFSR-driven spawning, collision detection, and score/high-score tracking.
- Advances only on a one-cycle `tick` enable from the frequency divider.
- Its registered outputs feed the display block's packed gamedata bus.

Parameters:
SLOTS, 4, number of concurrent obstacle slots (1..8)
XW, 8, width of horizontal positions
YW, 6, width of player height above ground
SCREEN_X, 160, spawn x position + 1; spawn at SCREEN_X-1
SPEED, 1, obstacle x decrement per tick
PLAYER_X, 16, player left edge
PLAYER_W, 8, player width
OBST_W, 6, obstacle width
OBST_H, 8, obstacle height
JUMP_V, 4, initial upward velocity (signed, YW+1 bits)
GRAVITY, 1, velocity decrement per tick
SPAWN_MIN_GAP, 24, minimum ticks between spawns
SPAWN_THRESH, 4, spawn when lfsr[3:0] < SPAWN_THRESH (16 = always)
SCOREW, 16, score width
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clock  in  1  system clock
rst  in  1  asynchronous active-high reset, clears all state
tick  in  1  game step enable, one clock wide
jump  in  1  raw jump button, level, synchronous to clock
state  out  2  00 IDLE, 01 RUN, 10 DEAD
player_y  out  YW  player height above ground
obst_x  out  SLOTS*XW  packed obstacle x positions, slot i at [i*XW +: XW]
obst_valid  out  SLOTS  per-slot active flag
score  out  SCOREW  current score
hi_score  out  SCOREW  best score since reset
collide  out  1  one-clock pulse on the RUN->DEAD transition

Behaviour:
- Reset: state=IDLE; player_y=0; velocity=0; obst_valid=0; obst_x=0; score=0; hi_score=0; collide=0; lfsr=LFSR_SEED; gap counter=SPAWN_MIN_GAP; jump latch=0. Reset is asynchronous and takes effect immediately, including mid-RUN.
- Jump input: rising edge of `jump` (previous-sample register) sets jump_req. jump_req is cleared on every tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, not only on ticks.
- All game updates occur on a clock edge with tick=1. Outputs are registered and visible the following cycle. Nothing changes when tick=0, except the LFSR and jump_req.
- IDLE:
  - jump_req on a tick -> RUN.
  - On entry to RUN: score=0, obstacles cleared, gap counter=SPAWN_MIN_GAP. That tick performs no physics.
- RUN, per tick, evaluated in this order from pre-tick values:
  1. Player. If y==0, vel==0 and jump_req: vel=JUMP_V, y unchanged. Otherwise, if airborne: if y+vel<=0 then y=0 and vel=0; else y=y+vel and vel=vel-GRAVITY. A jump_req while airborne is discarded.
  2. Obstacles. Each valid slot with x<SPEED becomes invalid. Each other valid slot gets x=x-SPEED.
  3. Spawn. Condition: gap>=SPAWN_MIN_GAP, lfsr[3:0]<SPAWN_THRESH, and at least one slot free in the pre-tick obst_valid. If met, the lowest-index free slot gets x=SCREEN_X-1 and valid=1, and gap resets to 0. If no slot is free, the spawn is suppressed and gap is not reset. A slot freed in this same tick is not reusable until the next tick. When no spawn occurs, gap increments, saturating at SPAWN_MIN_GAP.
  4. Collision, on the post-update values, for any valid slot: x<PLAYER_X+PLAYER_W, x+OBST_W>PLAYER_X and y<OBST_H. Width-extend by 1 bit, so there is no wrap.
     - Hit: state=DEAD, collide=1 for one clock, score unchanged, hi_score=max(hi_score, score).
     - No hit: score+1, saturating at all-ones.
- DEAD: all positions frozen. jump_req on a tick -> IDLE; positions, velocity and obstacles are cleared, and score is held.
- State encoding 11 is unreachable; if ever present it decodes to IDLE on the next tick.

Decomposition:
- Shared package (define.v): state encodings, default field widths, and the gamedata field offsets for player_y, obst_x, obst_valid and score. The display block unpacks the bus from these offsets.
- Sub-module obstacle_slot: one instance per slot via generate. It holds x and valid, and owns the move/expire/load logic.
- LFSR, player physics, spawn arbiter, collision detection and FSM remain in game_engine.

Test Plan:
- Reset check: assert rst mid-RUN -> state=00, player_y=0, obst_valid=0, score=0, hi_score=0 in the same cycle, with no clock edge required.
- Start and jump arc: jump edge in IDLE with tick, then a second jump edge. Over successive ticks player_y=4,7,9,10,10,9,7,4,0, then velocity stays 0. A jump pressed at y=9 is ignored.
- Collision: SPAWN_THRESH=16, SPEED=1, no jumping. The first RUN tick spawns slot0 at x=159; x decrements each tick. At x=23 -> collide pulse, state=10, score=136, hi_score=136.
- Slot exhaustion: SLOTS=2, SPAWN_MIN_GAP=0, SPAWN_THRESH=16 -> slots 0 and 1 spawn on consecutive ticks. Third spawn suppressed, obst_valid=2'b11, gap not reset.
- Expiry and spawn on the same tick: slot0 at x=0 expires as a spawn fires with slot1 valid -> no valid slot receives the spawn that tick. The next eligible tick loads slot0 at x=159.
- Restart: in DEAD, jump edge -> IDLE with obstacles cleared and hi_score held. A second run scores less than hi_score -> hi_score unchanged.
